fb_inst_enc: RTL and testbench

//  Instruction encoder: packs decoded fields (format, opcode, regs, funct, 32b imm) into a 32b RV32I word.

---
 rtl/fb_inst_enc.sv | 157 +++++++++++++++
 tb/tb_fb_inst_enc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fb_inst_enc.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word through a 2-stage valid/ready pipeline.
// Optional immediate range/alignment checking is enabled by defining FB_ENC_RANGE_CHK_EN.
module fb_inst_enc #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_in_fmt,
  input  logic [6:0]       i_in_opcode,
  input  logic [4:0]       i_in_rd,
  input  logic [4:0]       i_in_rs1,
  input  logic [4:0]       i_in_rs2,
  input  logic [2:0]       i_in_funct3,
  input  logic [6:0]       i_in_funct7,
  input  logic [31:0]      i_in_imm,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_inst,
  output logic             o_out_err,
  output logic [CNT_W-1:0] o_out_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic             r_s1_valid;
  logic [2:0]       r_fmt;
  logic [6:0]       r_opcode;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  logic [31:0]      r_imm;

  logic             r_s2_valid;
  logic [31:0]      r_inst;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_handoff;
  logic [31:0]      w_enc_inst;
  logic             w_fmt_err;
  logic             w_rng_err;

  assign w_s2_adv  = !r_s2_valid || i_out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_accept  = i_in_valid && w_s1_adv;
  assign w_handoff = r_s2_valid && i_out_ready;

  assign o_in_ready  = w_s1_adv;
  assign o_out_valid = r_s2_valid;
  assign o_out_inst  = r_inst;
  assign o_out_err   = r_err;
  assign o_out_cnt   = r_cnt;

`ifdef FB_ENC_RANGE_CHK_EN
  // True when imm[31:lsb] are all copies of one bit, i.e. imm fits as a signed (lsb+1)-bit value.
  function automatic logic f_sext_ok(input logic [31:0] v, input int lsb);
    logic [31:0] sh;
    sh = 32'($signed(v) >>> lsb);
    return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
  endfunction
`endif

  always_comb begin
    w_enc_inst = 32'h0000_0000;
    w_fmt_err  = 1'b0;
    case (r_fmt)
      FMT_R: w_enc_inst = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
      FMT_I: w_enc_inst = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
      FMT_S: w_enc_inst = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
      FMT_B: w_enc_inst = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                           r_imm[4:1], r_imm[11], r_opcode};
      FMT_U: w_enc_inst = {r_imm[31:12], r_rd, r_opcode};
      FMT_J: w_enc_inst = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
      default: begin
        w_enc_inst = 32'h0000_0000;
        w_fmt_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_rng_err = 1'b0;
`ifdef FB_ENC_RANGE_CHK_EN
    case (r_fmt)
      FMT_I, FMT_S: w_rng_err = !f_sext_ok(r_imm, 11);
      FMT_B:        w_rng_err = !f_sext_ok(r_imm, 12) || r_imm[0];
      FMT_J:        w_rng_err = !f_sext_ok(r_imm, 20) || r_imm[0];
      FMT_U:        w_rng_err = (r_imm[11:0] != 12'h000);
      default:      w_rng_err = 1'b0;
    endcase
`else
    w_rng_err = 1'b0;
`endif
  end

  // Stage 1 holds the raw fields until stage 2 can take them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_fmt      <= 3'd0;
      r_opcode   <= 7'd0;
      r_rd       <= 5'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_funct3   <= 3'd0;
      r_funct7   <= 7'd0;
      r_imm      <= 32'd0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_fmt      <= i_in_fmt;
      r_opcode   <= i_in_opcode;
      r_rd       <= i_in_rd;
      r_rs1      <= i_in_rs1;
      r_rs2      <= i_in_rs2;
      r_funct3   <= i_in_funct3;
      r_funct7   <= i_in_funct7;
      r_imm      <= i_in_imm;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 registers the encoded word; it stays frozen while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_inst     <= 32'h0000_0000;
      r_err      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_inst     <= w_enc_inst;
      r_err      <= w_fmt_err || w_rng_err;
    end
  end

  // Hand-off counter, wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_handoff) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fb_inst_enc.sv
// Directed self-checking bench for fb_inst_enc (works with or without FB_ENC_RANGE_CHK_EN).
module tb_fb_inst_enc;

  localparam int CNT_W = 4;
`ifdef FB_ENC_RANGE_CHK_EN
  localparam logic RNG = 1'b1;
`else
  localparam logic RNG = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fb_inst_enc #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_fmt    (in_fmt),
    .i_in_opcode (in_opcode),
    .i_in_rd     (in_rd),
    .i_in_rs1    (in_rs1),
    .i_in_rs2    (in_rs2),
    .i_in_funct3 (in_funct3),
    .i_in_funct7 (in_funct7),
    .i_in_imm    (in_imm),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_inst  (out_inst),
    .o_out_err   (out_err),
    .o_out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One word through an idle pipeline with out_ready high; checks the 2-cycle latency.
  task automatic do_single(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] exp_inst, input logic exp_err);
    @(negedge clk);
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_v1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_v2"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_inst"}, out_inst, exp_inst);
    check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  // Streams n addi words; out_ready is held low for the first 'stall' cycles.
  task automatic run_stream(input string tag, input int n, input int stall);
    logic [31:0] exp_q [16];
    int  tx = 0;
    int  rx = 0;
    int  cyc = 0;
    bit  rdy_chk = 1'b0;
    for (int i = 0; i < n; i++)
      exp_q[i] = {12'(i * 16 + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
    while (rx < n && cyc < 80) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (tx < n) begin
        set_fields(3'd1, 7'h13, 5'(tx + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(tx * 16 + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check_eq({tag, "_data"}, out_inst, exp_q[rx]);
        rx++;
      end else if (out_valid) begin
        check_eq({tag, "_hold"}, out_inst, exp_q[rx]);
      end
      if (stall > 0 && !rdy_chk && tx == 2 && !out_ready) begin
        check_eq({tag, "_full_rdy"}, 32'(in_ready), 32'd0);
        rdy_chk = 1'b1;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (rx < n) check_eq({tag, "_timeout"}, 32'(rx), 32'(n));
    if (stall > 0 && !rdy_chk) check_eq({tag, "_rdy_seen"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_inst", out_inst, 32'h0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    check_eq("rst_cnt", 32'(out_cnt), 32'd0);
    rst = 1'b0;

    do_single("r_add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 32'h002081B3, 1'b0);
    do_single("r_sub", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h402081B3, 1'b0);
    do_single("i_addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h7F, 32'd5, 32'h00500093, 1'b0);
    do_single("s_sw", 3'd2, 7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020A423, 1'b0);
    do_single("b_neg4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b0);
    do_single("u_lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h123452B7, 1'b0);
    do_single("j_jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h001000EF, 1'b0);
    do_single("fmt7", 3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h01, 32'd5, 32'h0, 1'b1);
    do_single("fmt6", 3'd6, 7'h6F, 5'd4, 5'd2, 5'd3, 3'd1, 7'h01, 32'h800, 32'h0, 1'b1);
    do_single("i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h80000093, RNG);
    do_single("u_low", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5FFF, 32'h123452B7, RNG);
    @(negedge clk);
    check_eq("cnt_singles", 32'(out_cnt), 32'd11);

    // Fresh counter, then 8 words with a 5-cycle downstream stall.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_stream("stream8", 8, 5);
    @(negedge clk);
    check_eq("cnt_stream", 32'(out_cnt), 32'd8);

    // Fill both stages, then reset asynchronously between clock edges.
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("full_valid", 32'(out_valid), 32'd1);
    check_eq("full_rdy", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_cnt", 32'(out_cnt), 32'd0);
    check_eq("arst_inst", out_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_single("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk);
    check_eq("cnt_post_rst", 32'(out_cnt), 32'd1);

    // 15 more hand-offs take the 4-bit counter from 1 through 15 and wrap to 0.
    run_stream("wrap", 15, 0);
    @(negedge clk);
    check_eq("cnt_wrap", 32'(out_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
